patch_row_summer: RTL and testbench
===================================

// Module: patch_row_summer
// PURPOSE
//  Transmit side of the patch row-sum interface: drives a patch reducer's init/partial_sum/partial_sum_valid inputs.
//  Accepts a ready/valid pixel stream from the DRAM read path, sums PATCH_SIZE pixels per row and emits one partial_sum per row.
//  After PATCH_SIZE rows it waits until the reducer's sum has been acknowledged, so a new patch's init is never lost.
// PARAMETERS
//  PATCH_SIZE    6   pixels per row and rows per patch (>=2)
//  PIXEL_SIZE    12  pixel width, unsigned
//  ROW_SUM_SIZE  15  partial_sum width; must be >= PIXEL_SIZE+log2(PATCH_SIZE) (checked at elaboration)
// PORTS
//  dram_clk          in   1             clock, all logic on posedge
//  reset             in   1             asynchronous, active-high
//  start             in   1             one-cycle request to process one patch; honoured only in IDLE
//  busy              out  1             high in every state except IDLE
//  done              out  1             one-cycle pulse when the patch has been acked downstream
//  pixel_data        in   PIXEL_SIZE    pixel value
//  pixel_valid       in   1             pixel_data valid
//  pixel_rdy         out  1             pixel accepted on a cycle where pixel_valid & pixel_rdy
//  init              out  1             to reducer: one-cycle pulse that clears its accumulator
//  partial_sum       out  ROW_SUM_SIZE  to reducer: row sum, registered
//  partial_sum_valid out  1             to reducer: one-cycle pulse per row, no backpressure
//  sum_rdy           in   1             from reducer: patch sum available
//  sum_ack           in   1             from the sum consumer to the reducer, snooped here
// BEHAVIOUR
//  Reset values: busy=0, done=0, pixel_rdy=0, init=0, partial_sum=0, partial_sum_valid=0.
//  Reset also clears state (->IDLE), the pixel counter, the row counter and the accumulator. Reset mid-patch abandons the patch.
//  States: IDLE, INIT, ACCUM, DRAIN.
//  IDLE: if start, go to INIT; init=1 on the next cycle.
//  INIT: lasts 1 cycle (init high), then go to ACCUM. The first partial_sum_valid is therefore never earlier than 1 cycle after init.
//  ACCUM: pixel_rdy=1 combinationally in this state only, so throughput is 1 pixel/cycle.
//   On accept, acc += zero-extended pixel and pix_cnt++.
//   On the accept where pix_cnt==PATCH_SIZE-1:
//    - partial_sum <= acc+pixel, partial_sum_valid=1 on the next cycle;
//    - acc <= 0, pix_cnt <= 0, row_cnt++.
//   Back-to-back row pulses are legal; partial_sum holds its value until the next row.
//   On the last pixel of row PATCH_SIZE-1, go to DRAIN and clear row_cnt.
//   pixel_valid=0 cycles stall the block with no state change.
//  DRAIN: pixel_rdy=0. Set seen_rdy when sum_rdy=1.
//   When seen_rdy & sum_ack & sum_rdy, pulse done next cycle, clear seen_rdy and go to IDLE.
//   If sum_rdy and sum_ack are both already high on the first DRAIN cycle, take the same exit.
//  start is ignored while busy; it is not queued.
//  Arithmetic: unsigned; the accumulator is ROW_SUM_SIZE wide and cannot overflow given the parameter rule.
//  Only the last pixel of a row causes a partial_sum_valid pulse, so a pulse with no pixels accepted is impossible.
// CONFIGURATION
//  PATCH_ROW_SUMMER_DARK_SUB_EN defined:
//   - adds input dark_offset[PIXEL_SIZE-1:0], sampled at the start cycle and held for the whole patch;
//   - each pixel contributes max(pixel-dark_offset, 0), with clamp at zero;
//   - latency is unchanged.
//  Macro undefined: the port is absent and raw pixels are summed.
// TESTING
//  1. start; 36 pixels all =1, valid every cycle
//     -> init pulse 1 cycle after start, then 6 partial_sum_valid pulses with partial_sum=6;
//     -> busy until done.
//  2. Pixel values 0..35 in order -> partial_sums 15,51,87,123,159,195.
//  3. All pixels 4095, PATCH_SIZE=6 -> partial_sum=24570 with no wrap; the reducer model's sum = 147420.
//  4. pixel_valid toggles 1/0 at random -> same sums as scenario 2;
//     -> partial_sum_valid never high for 2 cycles with identical row index.
//  5. In DRAIN, hold sum_ack=0 for 20 cycles after sum_rdy -> no done and no pixel_rdy; ack -> done 1 cycle later.
//     Then a start issued in the same cycle as done is ignored.
//  6. Assert reset during row 3 -> all outputs 0 next edge;
//     -> a following start yields a clean patch with correct sums.
//     With DARK_SUB_EN, offset=2 and pixels=1 -> partial_sum=0.

Source files
------------

// File: rtl/patch_row_summer.sv
// Patch row summer: transmit side of the patch row-sum interface.
// Sums PATCH_SIZE pixels per row. It emits one registered partial_sum per row to a patch reducer.
// After PATCH_SIZE rows it waits until the reducer's patch sum has been acknowledged.
// Optional feature macro: PATCH_ROW_SUMMER_DARK_SUB_EN. It adds a dark_offset input. Each pixel
// then contributes max(pixel - dark_offset, 0) instead of its raw value.
module patch_row_summer #(
  parameter int unsigned PATCH_SIZE   = 6,
  parameter int unsigned PIXEL_SIZE   = 12,
  parameter int unsigned ROW_SUM_SIZE = 15
) (
  input  logic                    dram_clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic [PIXEL_SIZE-1:0]   pixel_data,
  input  logic                    pixel_valid,
  output logic                    pixel_rdy,
`ifdef PATCH_ROW_SUMMER_DARK_SUB_EN
  input  logic [PIXEL_SIZE-1:0]   dark_offset,
`endif
  output logic                    init,
  output logic [ROW_SUM_SIZE-1:0] partial_sum,
  output logic                    partial_sum_valid,
  input  logic                    sum_rdy,
  input  logic                    sum_ack
);

  localparam int unsigned CntW = $clog2(PATCH_SIZE);
  localparam logic [CntW-1:0] CntLast = CntW'(PATCH_SIZE - 1);

  // Reject parameter sets that could overflow the accumulator or make counters degenerate.
  if (PATCH_SIZE < 2 || ROW_SUM_SIZE < PIXEL_SIZE + $clog2(PATCH_SIZE)) begin : g_bad_cfg
    $error("patch_row_summer: illegal PATCH_SIZE/ROW_SUM_SIZE combination");
  end

  typedef enum logic [1:0] {StIdle, StInit, StAccum, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         pix_cnt_q, row_cnt_q;
  logic [ROW_SUM_SIZE-1:0] acc_q, acc_sum, partial_sum_q;
  logic                    psv_q, done_q, done_d, seen_rdy_q, seen_rdy_d;
  logic                    accept, row_end, start_ok;
  logic [PIXEL_SIZE-1:0]   pix_eff;

  // A start coinciding with the done pulse is dropped, so back-to-back patches need a fresh start.
  assign start_ok = (state_q == StIdle) && start && !done_q;

`ifdef PATCH_ROW_SUMMER_DARK_SUB_EN
  logic [PIXEL_SIZE-1:0] dark_q;

  // Capture the dark offset with the accepted start and hold it for the whole patch.
  always_ff @(posedge dram_clk or posedge reset) begin
    if (reset) begin
      dark_q <= '0;
    end else if (start_ok) begin
      dark_q <= dark_offset;
    end
  end

  // Dark-subtracted pixel, clamped at zero.
  always_comb begin
    pix_eff = '0;
    if (pixel_data > dark_q) begin
      pix_eff = pixel_data - dark_q;
    end
  end
`else
  assign pix_eff = pixel_data;
`endif

  assign acc_sum = acc_q + ROW_SUM_SIZE'(pix_eff);

  // Next-state, handshake and decoded outputs.
  always_comb begin
    state_d    = state_q;
    seen_rdy_d = seen_rdy_q;
    done_d     = 1'b0;
    pixel_rdy  = 1'b0;
    accept     = 1'b0;
    row_end    = 1'b0;
    busy       = (state_q != StIdle);
    init       = (state_q == StInit);
    case (state_q)
      StIdle: begin
        if (start_ok) state_d = StInit;
      end
      StInit: begin
        state_d = StAccum;
      end
      StAccum: begin
        pixel_rdy = 1'b1;
        accept    = pixel_valid;
        row_end   = accept && (pix_cnt_q == CntLast);
        if (row_end && (row_cnt_q == CntLast)) state_d = StDrain;
      end
      StDrain: begin
        if (sum_rdy) seen_rdy_d = 1'b1;
        // The current-cycle sum_rdy covers the case where rdy and ack are both already high.
        if ((seen_rdy_q || sum_rdy) && sum_ack && sum_rdy) begin
          done_d     = 1'b1;
          seen_rdy_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters, accumulator and registered reducer-facing outputs.
  always_ff @(posedge dram_clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      pix_cnt_q     <= '0;
      row_cnt_q     <= '0;
      acc_q         <= '0;
      partial_sum_q <= '0;
      psv_q         <= 1'b0;
      done_q        <= 1'b0;
      seen_rdy_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      seen_rdy_q <= seen_rdy_d;
      psv_q      <= row_end;
      if (accept) begin
        if (row_end) begin
          partial_sum_q <= acc_sum;
          acc_q         <= '0;
          pix_cnt_q     <= '0;
          row_cnt_q     <= (row_cnt_q == CntLast) ? '0 : row_cnt_q + 1'b1;
        end else begin
          acc_q     <= acc_sum;
          pix_cnt_q <= pix_cnt_q + 1'b1;
        end
      end
    end
  end

  assign partial_sum       = partial_sum_q;
  assign partial_sum_valid = psv_q;
  assign done              = done_q;

endmodule

// File: tb/tb_patch_row_summer.sv
// Directed bench for patch_row_summer with a small reducer model snooping the row pulses.
module tb_patch_row_summer;

  logic        dram_clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, pixel_rdy, init, partial_sum_valid;
  logic [11:0] pixel_data = '0;
  logic        pixel_valid = 1'b0;
  logic [14:0] partial_sum;
  logic        sum_rdy = 1'b0;
  logic        sum_ack = 1'b0;
`ifdef PATCH_ROW_SUMMER_DARK_SUB_EN
  logic [11:0] dark_offset = '0;
`endif

  int n_assert = 0;
  int n_fail = 0;

  logic [14:0] got_q[$];
  int          reducer_sum = 0;
  logic        prev_psv = 1'b0;

  always #5 dram_clk = ~dram_clk;

  patch_row_summer #(
    .PATCH_SIZE  (6),
    .PIXEL_SIZE  (12),
    .ROW_SUM_SIZE(15)
  ) dut (
    .dram_clk         (dram_clk),
    .reset            (reset),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .pixel_data       (pixel_data),
    .pixel_valid      (pixel_valid),
    .pixel_rdy        (pixel_rdy),
`ifdef PATCH_ROW_SUMMER_DARK_SUB_EN
    .dark_offset      (dark_offset),
`endif
    .init             (init),
    .partial_sum      (partial_sum),
    .partial_sum_valid(partial_sum_valid),
    .sum_rdy          (sum_rdy),
    .sum_ack          (sum_ack)
  );

  // Reducer model: init clears it, each row pulse adds partial_sum.
  always @(negedge dram_clk) begin
    if (reset) begin
      prev_psv = 1'b0;
    end else begin
      if (init) begin
        got_q.delete();
        reducer_sum = 0;
      end
      if (partial_sum_valid) begin
        got_q.push_back(partial_sum);
        reducer_sum += int'(partial_sum);
        n_assert++;
        assert (!prev_psv) else begin
          n_fail++;
          $error("FAIL psv_double: observed 2 consecutive pulses, expected 1");
        end
      end
      prev_psv = partial_sum_valid;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pix_val(input int mode, input int idx);
    case (mode)
      0:       return 12'd1;
      1:       return 12'(idx);
      2:       return 12'hFFF;
      default: return 12'd1;
    endcase
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pixel_rdy"}, 32'(pixel_rdy), 0);
    chk({tag, "_init"}, 32'(init), 0);
    chk({tag, "_partial_sum"}, 32'(partial_sum), 0);
    chk({tag, "_psv"}, 32'(partial_sum_valid), 0);
  endtask

  task automatic do_start();
    @(negedge dram_clk);
    start = 1'b1;
    @(negedge dram_clk);
    start = 1'b0;
    chk("init_pulse", 32'(init), 1);
    chk("busy_in_init", 32'(busy), 1);
    chk("no_rdy_in_init", 32'(pixel_rdy), 0);
  endtask

  // Offer pixels until npix are accepted; rnd toggles pixel_valid randomly.
  task automatic feed(input int mode, input int npix, input bit rnd);
    int idx = 0;
    int cyc = 0;
    while (idx < npix && cyc < 1000) begin
      @(negedge dram_clk);
      cyc++;
      pixel_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pixel_data  = pix_val(mode, idx);
      #1;
      if (pixel_valid && pixel_rdy) idx++;
    end
    @(negedge dram_clk);
    pixel_valid = 1'b0;
    chk("feed_budget", 32'(idx), 32'(npix));
  endtask

  // Called at a negedge in DRAIN; hold cycles of sum_rdy without sum_ack, then acknowledge.
  task automatic drain(input int hold);
    chk("drain_busy", 32'(busy), 1);
    chk("drain_no_done", 32'(done), 0);
    sum_rdy = 1'b1;
    sum_ack = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge dram_clk);
      chk("hold_no_done", 32'(done), 0);
      chk("hold_no_rdy", 32'(pixel_rdy), 0);
    end
    sum_ack = 1'b1;
    @(negedge dram_clk);
    chk("done_pulse", 32'(done), 1);
    chk("idle_at_done", 32'(busy), 0);
    start   = 1'b1;
    sum_rdy = 1'b0;
    sum_ack = 1'b0;
    @(negedge dram_clk);
    start = 1'b0;
    chk("done_one_cycle", 32'(done), 0);
    chk("start_at_done_ignored_init", 32'(init), 0);
    chk("start_at_done_ignored_busy", 32'(busy), 0);
  endtask

  task automatic chk_rows(input int ex[6], input int total);
    chk("row_count", 32'(got_q.size()), 6);
    for (int r = 0; r < 6 && r < got_q.size(); r++) begin
      chk($sformatf("row%0d_sum", r), 32'(got_q[r]), 32'(ex[r]));
    end
    chk("reducer_total", 32'(reducer_sum), 32'(total));
  endtask

  initial begin
    int ex_one[6]  = '{6, 6, 6, 6, 6, 6};
    int ex_ramp[6] = '{15, 51, 87, 123, 159, 195};
    int ex_max[6]  = '{24570, 24570, 24570, 24570, 24570, 24570};

    repeat (2) @(negedge dram_clk);
    chk_reset_outputs("reset");
    reset = 1'b0;

    // All ones, valid every cycle, both rdy and ack high on the first DRAIN cycle.
    do_start();
    feed(0, 36, 1'b0);
    drain(0);
    chk_rows(ex_one, 36);

    // Ramp 0..35 with a long ack hold-off in DRAIN.
    do_start();
    feed(1, 36, 1'b0);
    drain(20);
    chk_rows(ex_ramp, 630);

    // Full-scale pixels: no wrap in the row sum.
    do_start();
    feed(2, 36, 1'b0);
    drain(1);
    chk_rows(ex_max, 147420);

    // Ramp with randomly gapped pixel_valid.
    do_start();
    feed(1, 36, 1'b1);
    drain(3);
    chk_rows(ex_ramp, 630);

    // Abandon a patch partway through the third row via asynchronous reset.
    do_start();
    feed(1, 15, 1'b0);
    chk("pre_reset_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    @(negedge dram_clk);
    chk_reset_outputs("midreset_edge");
    reset = 1'b0;
    do_start();
    feed(1, 36, 1'b0);
    drain(2);
    chk_rows(ex_ramp, 630);

`ifdef PATCH_ROW_SUMMER_DARK_SUB_EN
    // Offset above the pixel value clamps every contribution to zero; offset is held from start.
    begin
      int ex_zero[6] = '{0, 0, 0, 0, 0, 0};
      dark_offset = 12'd2;
      do_start();
      dark_offset = 12'd0;
      feed(3, 36, 1'b0);
      drain(0);
      chk_rows(ex_zero, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
